util_fir_int_ctrl: RTL and testbench

//  Sample scheduler and mode sequencer for util_fir_int. Takes a 32-bit I/Q stream
//  ({ch1,ch0}) from the DAC sample source and issues it to the FIR s_axis port at the
//  DAC slot rate: every cycle in bypass, every RATIO cycles in interpolate mode.

---
 rtl/util_fir_int_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_util_fir_int_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/util_fir_int_ctrl.sv
// rtl/util_fir_int_ctrl.sv - sample scheduler and mode sequencer for util_fir_int
//
// Purpose: issues the 32-bit {ch1,ch0} DAC sample stream to the FIR s_axis port
// at the slot rate (every cycle in bypass, every RATIO cycles in interpolate).
// Owns the FIR interpolate/dac_read controls and only changes mode after the FIR
// path has been quiet for DRAIN_CYCLES. Missed slots are filled with zero samples
// and counted in a saturating underflow counter.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   enable, mode_req       run request, requested mode (1 = interpolate)
//   src_valid/ready/data   upstream sample stream
//   fir_tvalid/tready/tdata  FIR s_axis data stream
//   fir_interpolate        FIR interpolate control
//   fir_dac_read           FIR dac_read control
//   busy                   draining or switching mode
//   underflow_cnt          saturating count of zero-filled slots

module util_fir_int_ctrl #(
    parameter int RATIO        = 8,
    parameter int DRAIN_CYCLES = 64,
    parameter int CNT_W        = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             enable,
    input  logic             mode_req,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [31:0]      src_data,
    output logic             fir_tvalid,
    input  logic             fir_tready,
    output logic [31:0]      fir_tdata,
    output logic             fir_interpolate,
    output logic             fir_dac_read,
    output logic             busy,
    output logic [CNT_W-1:0] underflow_cnt
);

    localparam int SLOT_W = $clog2(RATIO);
    localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(RATIO - 1);
    localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_SWITCH} state_t;

    state_t             state_q, state_d;
    logic               interp_q, interp_d;
    logic               dac_read_q;
    logic               busy_q;
    logic               tvalid_q, tvalid_d;
    logic [31:0]        tdata_q, tdata_d;
    logic [31:0]        hold_q, hold_d;
    logic               hold_valid_q, hold_valid_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic [CNT_W-1:0]   uf_q, uf_d;
    logic               started_q, started_d;

    logic in_run, stall, xfer, slot_last, strobe, issue, load;

    assign in_run    = (state_q == S_RUN);
    assign stall     = tvalid_q && !fir_tready;
    assign xfer      = tvalid_q && fir_tready;
    assign slot_last = interp_q ? (slot_q == SLOT_LAST) : 1'b1;
    assign strobe    = in_run && (slot_q == '0) && !stall;
    // Before the first sample after IDLE an empty slot is simply skipped,
    // so start-up does not register as underflow.
    assign issue     = strobe && (hold_valid_q || started_q);
    // The hold register unloads on a strobe edge, so it can accept a new
    // sample in that same cycle; this keeps bypass at one sample per cycle.
    assign src_ready = in_run && (!hold_valid_q || strobe);
    assign load      = src_valid && src_ready;

    always_comb begin
        state_d      = state_q;
        interp_d     = interp_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        slot_d       = '0;
        drain_d      = '0;
        uf_d         = uf_q;
        started_d    = started_q;

        if (issue) begin
            tvalid_d = 1'b1;
            if (hold_valid_q) begin
                tdata_d      = hold_q;
                hold_valid_d = 1'b0;
            end else begin
                tdata_d = '0;
                if (!(&uf_q)) begin
                    uf_d = uf_q + CNT_W'(1);
                end
            end
        end else if (xfer) begin
            tvalid_d = 1'b0;
        end

        if (load) begin
            hold_d       = src_data;
            hold_valid_d = 1'b1;
        end

        if (state_q == S_IDLE) begin
            started_d = 1'b0;
        end else if (load) begin
            started_d = 1'b1;
        end

        // Slot counter freezes while the FIR holds off, so slots are delayed, never dropped.
        if (in_run) begin
            if (stall) begin
                slot_d = slot_q;
            end else if (!slot_last) begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = (mode_req == interp_q) ? S_RUN : S_SWITCH;
                end
            end
            S_RUN: begin
                if (!enable || (mode_req != interp_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Any transfer restarts the quiet-time window.
                if (xfer) begin
                    drain_d = '0;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = enable ? S_SWITCH : S_IDLE;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            S_SWITCH: begin
                interp_d = mode_req;
                state_d  = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            interp_q     <= 1'b0;
            dac_read_q   <= 1'b0;
            busy_q       <= 1'b0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            slot_q       <= '0;
            drain_q      <= '0;
            uf_q         <= '0;
            started_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            interp_q     <= interp_d;
            dac_read_q   <= (state_d == S_RUN) && !interp_d;
            busy_q       <= (state_d == S_DRAIN) || (state_d == S_SWITCH);
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            slot_q       <= slot_d;
            drain_q      <= drain_d;
            uf_q         <= uf_d;
            started_q    <= started_d;
        end
    end

    assign fir_tvalid      = tvalid_q;
    assign fir_tdata       = tdata_q;
    assign fir_interpolate = interp_q;
    assign fir_dac_read    = dac_read_q;
    assign busy            = busy_q;
    assign underflow_cnt   = uf_q;

endmodule

// File: tb/tb_util_fir_int_ctrl.sv
// tb/tb_util_fir_int_ctrl.sv - self-checking bench for util_fir_int_ctrl

module tb_util_fir_int_ctrl;

    localparam int RATIO = 8;
    localparam int DRAIN = 64;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_DRAIN = 2, ST_SWITCH = 3;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        enable, mode_req, src_valid, fir_tready;
    logic [31:0] src_data;
    logic        src_ready, fir_tvalid, fir_interpolate, fir_dac_read, busy;
    logic [31:0] fir_tdata;
    logic [15:0] underflow_cnt;

    logic        s_src_ready, s_tvalid, s_interp, s_dac, s_busy;
    logic [31:0] s_tdata;
    logic [2:0]  s_uf;

    int n_vec = 0;
    int n_err = 0;

    bit          src_inc;
    logic [31:0] src_const;
    logic [31:0] seq;
    logic [31:0] hs_log[$];

    // behavioural model state
    int          m_st, m_wait, m_quiet, m_uf, m_acc_total;
    bit          m_interp, m_tv, m_started, m_accepted;
    logic [31:0] m_td;
    logic [31:0] m_hold[$];

    util_fir_int_ctrl #(.RATIO(RATIO), .DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .mode_req(mode_req),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .fir_tvalid(fir_tvalid), .fir_tready(fir_tready), .fir_tdata(fir_tdata),
        .fir_interpolate(fir_interpolate), .fir_dac_read(fir_dac_read),
        .busy(busy), .underflow_cnt(underflow_cnt)
    );

    util_fir_int_ctrl #(.RATIO(RATIO), .DRAIN_CYCLES(DRAIN), .CNT_W(3)) u_sat (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .mode_req(mode_req),
        .src_valid(src_valid), .src_ready(s_src_ready), .src_data(src_data),
        .fir_tvalid(s_tvalid), .fir_tready(fir_tready), .fir_tdata(s_tdata),
        .fir_interpolate(s_interp), .fir_dac_read(s_dac),
        .busy(s_busy), .underflow_cnt(s_uf)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    task automatic m_reset();
        m_st = ST_IDLE; m_wait = 0; m_quiet = 0; m_uf = 0; m_acc_total = 0;
        m_interp = 0; m_tv = 0; m_started = 0; m_accepted = 0; m_td = '0;
        m_hold.delete();
    endtask

    function automatic bit m_slot_now();
        return (m_st == ST_RUN) && (m_wait == 0) && !(m_tv && !fir_tready);
    endfunction

    function automatic bit m_ready_now();
        return (m_st == ST_RUN) && ((m_hold.size() == 0) || m_slot_now());
    endfunction

    task automatic m_step();
        bit slot, produce, hs, stall;
        int period;
        hs      = m_tv && fir_tready;
        stall   = m_tv && !fir_tready;
        slot    = m_slot_now();
        produce = slot && ((m_hold.size() != 0) || m_started);
        m_accepted = src_valid && m_ready_now();
        period  = m_interp ? RATIO : 1;

        if (produce) begin
            m_tv = 1;
            if (m_hold.size() != 0) m_td = m_hold.pop_front();
            else begin
                m_td = '0;
                m_uf++;
            end
        end else if (hs) begin
            m_tv = 0;
        end
        if (m_accepted) begin
            m_hold.push_back(src_data);
            m_started = 1;
            m_acc_total++;
        end

        case (m_st)
            ST_IDLE: begin
                m_started = 0;
                m_wait = 0;
                if (enable) m_st = (mode_req == m_interp) ? ST_RUN : ST_SWITCH;
            end
            ST_RUN: begin
                if (!stall) m_wait = (m_wait == 0) ? period - 1 : m_wait - 1;
                if (!enable || (mode_req != m_interp)) begin
                    m_st = ST_DRAIN;
                    m_quiet = 0;
                end
            end
            ST_DRAIN: begin
                if (hs) m_quiet = 0;
                else if (m_quiet == DRAIN - 1) m_st = enable ? ST_SWITCH : ST_IDLE;
                else m_quiet++;
            end
            default: begin
                m_interp = mode_req;
                m_st = ST_RUN;
                m_wait = 0;
            end
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge aclk or negedge aresetn);
            if (!aresetn) m_reset();
            else m_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge aclk);
            chk("src_ready", src_ready, m_ready_now());
            chk("fir_tvalid", fir_tvalid, m_tv);
            chk("fir_tdata", fir_tdata, m_td);
            chk("fir_interpolate", fir_interpolate, m_interp);
            chk("fir_dac_read", fir_dac_read, (m_st == ST_RUN) && !m_interp);
            chk("busy", busy, (m_st == ST_DRAIN) || (m_st == ST_SWITCH));
            chk("underflow_cnt", underflow_cnt, (m_uf > 65535) ? 65535 : m_uf);
            chk("sat_underflow_cnt", s_uf, (m_uf > 7) ? 7 : m_uf);
            if (aresetn && fir_tvalid && fir_tready) hs_log.push_back(fir_tdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_src();
        src_data = src_inc ? seq : src_const;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        if (m_accepted) seq++;
        drive_src();
    endtask

    task automatic do_reset();
        aresetn = 0; enable = 0; mode_req = 0; src_valid = 0; fir_tready = 0;
        src_inc = 0; src_const = '0; seq = 32'd1;
        drive_src();
        repeat (2) @(posedge aclk);
        #1;
        hs_log.delete();
        aresetn = 1;
    endtask

    task automatic check_seq(input string name);
        for (int i = 0; i < hs_log.size(); i++) chk(name, hs_log[i], i + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt_tv, cnt_rdy, gap, guard;

        // reset state
        aresetn = 0; enable = 0; mode_req = 0; src_valid = 0; fir_tready = 0;
        src_inc = 0; src_const = '0; seq = 32'd1; drive_src();
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_tvalid", fir_tvalid, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_interp", fir_interpolate, 0);
        chk("rst_uf", underflow_cnt, 0);
        chk("rst_busy", busy, 0);

        // 1: bypass, constant sample
        do_reset();
        enable = 1; src_valid = 1; fir_tready = 1; src_const = 32'h40002000; drive_src();
        repeat (20) tick();
        chk("byp_tdata", fir_tdata, 32'h40002000);
        chk("byp_dac", fir_dac_read, 1);
        cnt_tv = 0;
        for (int i = 0; i < 10; i++) begin tick(); cnt_tv += fir_tvalid; end
        chk("byp_tvalid_cnt", cnt_tv, 10);
        chk("byp_uf", underflow_cnt, 0);

        // 2: interpolate from reset
        do_reset();
        enable = 1; mode_req = 1; src_valid = 1; fir_tready = 1; src_inc = 1; drive_src();
        repeat (40) tick();
        cnt_tv = 0; cnt_rdy = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            cnt_tv += fir_tvalid;
            cnt_rdy += src_ready;
        end
        chk("int_tvalid_cnt", cnt_tv, 4);
        chk("int_ready_cnt", cnt_rdy, 4);
        chk("int_interp", fir_interpolate, 1);
        chk("int_dac", fir_dac_read, 0);
        check_seq("int_seq");

        // 3: underflow and saturation
        do_reset();
        enable = 1; mode_req = 1; src_valid = 1; fir_tready = 1; src_inc = 1; drive_src();
        guard = 0;
        while (m_acc_total < 3 && guard < 200) begin tick(); guard++; end
        chk("uf_feed_done", m_acc_total, 3);
        src_valid = 0;
        repeat (48) tick();
        chk("uf_cnt5", underflow_cnt, 5);
        chk("uf_sat_cnt5", s_uf, 5);
        repeat (40) tick();
        chk("uf_cnt10", underflow_cnt, 10);
        chk("uf_sat_hold", s_uf, 7);

        // 4: bypass -> interpolate switch
        do_reset();
        enable = 1; src_valid = 1; fir_tready = 1; src_inc = 1; drive_src();
        repeat (20) tick();
        mode_req = 1;
        tick();
        chk("sw_busy", busy, 1);
        chk("sw_interp_old", fir_interpolate, 0);
        gap = 0;
        tick();
        while (!fir_tvalid && gap < 200) begin gap++; tick(); end
        chk("sw_gap", gap, 66);
        chk("sw_interp_new", fir_interpolate, 1);
        chk("sw_busy_done", busy, 0);
        repeat (30) tick();
        check_seq("sw_seq");
        chk("sw_uf", underflow_cnt, 0);

        // 5: backpressure
        do_reset();
        enable = 1; src_valid = 1; fir_tready = 1; src_inc = 1; drive_src();
        repeat (10) tick();
        fir_tready = 0;
        repeat (10) tick();
        fir_tready = 1;
        repeat (10) tick();
        chk("bp_len_ok", hs_log.size() >= 12, 1);
        check_seq("bp_seq");
        chk("bp_uf", underflow_cnt, 0);

        // 6a: async reset in DRAIN
        do_reset();
        enable = 1; src_valid = 1; fir_tready = 1; src_inc = 1; drive_src();
        repeat (10) tick();
        enable = 0;
        repeat (5) tick();
        chk("rd_busy_pre", busy, 1);
        #2;
        aresetn = 0;
        #1;
        chk("rd_tvalid", fir_tvalid, 0);
        chk("rd_tdata", fir_tdata, 0);
        chk("rd_busy", busy, 0);
        chk("rd_dac", fir_dac_read, 0);
        chk("rd_src_ready", src_ready, 0);
        @(posedge aclk);
        #1;
        aresetn = 1;
        repeat (3) tick();
        chk("rd_idle_busy", busy, 0);
        chk("rd_idle_ready", src_ready, 0);

        // 6b: enable drop in interpolate RUN -> IDLE, mode kept
        do_reset();
        enable = 1; mode_req = 1; src_valid = 1; fir_tready = 1; src_inc = 1; drive_src();
        repeat (30) tick();
        enable = 0;
        tick();
        chk("dr_busy", busy, 1);
        guard = 0;
        while (busy && guard < 300) begin tick(); guard++; end
        chk("dr_done", busy, 0);
        chk("dr_interp_kept", fir_interpolate, 1);
        chk("dr_dac", fir_dac_read, 0);
        repeat (10) tick();
        chk("dr_tvalid", fir_tvalid, 0);
        chk("dr_src_ready", src_ready, 0);

        @(negedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
